// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
// Shared definitions for the float datapath (tmul, tdiv):
//   state_e     - sequencing states of the iterative arithmetic units
//   op_class_e  - operand classification (zero/subnormal/normal/inf/NaN)
//   bias()      - exponent bias for a given exponent width
//   exp_ones()  - all-ones exponent field value
//   canon_nan() - canonical quiet NaN word (sign 0, exp all-ones, frac MSB 1)
//   classify()  - classify an operand from its exponent/fraction flags
// -----------------------------------------------------------------------------
package float_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_MUL  = 3'd2,
        ST_NORM = 3'd3,
        ST_RND  = 3'd4,
        ST_OUT  = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } op_class_e;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned exp_ones(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

    function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned fra_w);
        return (64'(exp_ones(exp_w)) << fra_w) | (64'd1 << (fra_w - 1));
    endfunction

    function automatic op_class_e classify(input logic exp_zero, input logic exp_all_ones,
                                           input logic frac_zero);
        if (exp_zero)
            return frac_zero ? CLS_ZERO : CLS_SUB;
        if (exp_all_ones)
            return frac_zero ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/float_round.sv
// -----------------------------------------------------------------------------
// float_round
// Round-to-nearest-even of a normalised (or subnormal) significand, with
// exponent carry and overflow to infinity.
//   sign        in  result sign
//   biased_exp  in  EXP+2  biased exponent, non-negative (0 = subnormal range)
//   sig         in  FRA+1  significand including hidden bit
//   guard       in  first bit below the significand LSB
//   round       in  second bit below the LSB
//   sticky      in  OR of all remaining lower bits
//   word        out EXP+FRA+1  packed {sign, exp, frac}
// -----------------------------------------------------------------------------
module float_round
    import float_pkg::*;
#(
    parameter int EXP = 5,
    parameter int FRA = 10
) (
    input  logic             sign,
    input  logic [EXP+1:0]   biased_exp,
    input  logic [FRA:0]     sig,
    input  logic             guard,
    input  logic             round,
    input  logic             sticky,
    output logic [EXP+FRA:0] word
);
    localparam int EW = EXP + 2;
    localparam logic [EW-1:0]  EMAX  = EW'(exp_ones(EXP));
    localparam logic [EXP-1:0] EONES = EXP'(exp_ones(EXP));

    logic            up;
    logic [FRA+1:0]  sum;
    logic [EW-1:0]   e_out;

    always_comb begin
        up  = guard & (round | sticky | sig[0]);
        sum = {1'b0, sig} + {{(FRA+1){1'b0}}, up};
        // In the subnormal range the hidden bit is 0; rounding into it promotes
        // the result to the smallest normal exponent.
        if (biased_exp == '0)
            e_out = {{(EW-1){1'b0}}, sum[FRA]};
        else
            e_out = biased_exp + {{(EW-1){1'b0}}, sum[FRA+1]};
        // On a carry the fraction bits are all zero, so sum[FRA-1:0] is valid
        // in both the carry and no-carry case.
        if (e_out >= EMAX)
            word = {sign, EONES, {FRA{1'b0}}};
        else
            word = {sign, e_out[EXP-1:0], sum[FRA-1:0]};
    end

endmodule

// File: rtl/tmul.sv
// -----------------------------------------------------------------------------
// tmul
// Iterative floating-point multiplier, AXI-Stream operands and result.
// Shift-add over FRA+1 multiplier bits, then normalise, round (RNE), hold.
// Optional macro TMUL_SUBNORMAL_EN: full subnormal input/output support;
// when undefined subnormal inputs act as zero and underflow flushes to zero.
//
// Handshakes: an input transfer happens on a rising edge where tvalid and
// tready are both high; tready never depends on tvalid. A and B share one
// handshake (both tvalids required). The result transfers on m_axis_tvalid &
// m_axis_tready; tdata is stable while tvalid is high.
//
//   aclk, aresetn            clock, async active-low reset
//   s_axis_a_*  / s_axis_b_* operand channels {sign, exp, frac}
//   m_axis_*                 product channel
//   dbg_state                current FSM state
// -----------------------------------------------------------------------------
module tmul
    import float_pkg::*;
#(
    parameter int EXP = 5,
    parameter int FRA = 10
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [EXP+FRA:0] s_axis_a_tdata,
    input  logic             s_axis_a_tvalid,
    output logic             s_axis_a_tready,
    input  logic [EXP+FRA:0] s_axis_b_tdata,
    input  logic             s_axis_b_tvalid,
    output logic             s_axis_b_tready,
    output logic [EXP+FRA:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output state_e           dbg_state
);
    localparam int W  = EXP + FRA + 1;
    localparam int SW = FRA + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP + 2;
    localparam int CW = $clog2(SW);
    localparam logic [EW-1:0]  BIAS_E    = EW'(bias(EXP));
    localparam logic [EXP-1:0] EONES     = EXP'(exp_ones(EXP));
    localparam logic [W-1:0]   NAN_W     = W'(canon_nan(EXP, FRA));
    localparam logic [CW-1:0]  LAST_ITER = CW'(SW - 1);
`ifdef TMUL_SUBNORMAL_EN
    localparam bit SUBN_EN = 1'b1;
`else
    localparam bit SUBN_EN = 1'b0;
`endif

    // Returns {exponent (signed, unbiased-by-one-step), significand}.
    // Subnormals are left-normalised so the significand always has bit FRA set.
    function automatic logic [EW+SW-1:0] unpack(input logic [W-1:0] x);
        logic [EXP-1:0] e;
        logic [FRA-1:0] f;
        logic [EW-1:0]  ex;
        logic [SW-1:0]  sg;
`ifdef TMUL_SUBNORMAL_EN
        int lz;
        bit found;
`endif
        e  = x[W-2:FRA];
        f  = x[FRA-1:0];
        ex = {2'b00, e};
        sg = {1'b1, f};
`ifdef TMUL_SUBNORMAL_EN
        if (e == '0) begin
            lz    = 0;
            found = 1'b0;
            for (int i = FRA - 1; i >= 0; i--) begin
                if (!found) begin
                    if (f[i]) found = 1'b1;
                    else      lz    = lz + 1;
                end
            end
            sg = {1'b0, f} << (lz + 1);
            ex = '0 - EW'(lz);
        end
`endif
        return {ex, sg};
    endfunction

    function automatic op_class_e class_of(input logic [W-1:0] x);
        return classify(x[W-2:FRA] == '0, x[W-2:FRA] == EONES, x[FRA-1:0] == '0);
    endfunction

    state_e               state_q, state_d;
    logic [W-1:0]         a_q, b_q, res_q;
    logic                 sign_q, nan_q, inf_q, zero_q, flush_q, sticky_q;
    logic signed [EW-1:0] exp_q;
    logic [PW-1:0]        acc_q, mcand_q;
    logic [SW-1:0]        mplier_q;
    logic [CW-1:0]        cnt_q;

    // ---------------- operand unpack / classification (PRE) ----------------
    logic [EW+SW-1:0] up_a, up_b;
    op_class_e        cls_a, cls_b;
    logic             a_zero, b_zero, a_inf, b_inf, pre_nan;

    always_comb begin
        up_a    = unpack(a_q);
        up_b    = unpack(b_q);
        cls_a   = class_of(a_q);
        cls_b   = class_of(b_q);
        a_zero  = (cls_a == CLS_ZERO) || (!SUBN_EN && cls_a == CLS_SUB);
        b_zero  = (cls_b == CLS_ZERO) || (!SUBN_EN && cls_b == CLS_SUB);
        a_inf   = (cls_a == CLS_INF);
        b_inf   = (cls_b == CLS_INF);
        pre_nan = (cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
                  (a_inf && b_zero) || (a_zero && b_inf);
    end

    // ---------------- normalisation (NORM) ----------------
    logic [PW-1:0]        n_m;
    logic signed [EW-1:0] n_e;
    logic                 n_st, n_flush;
`ifdef TMUL_SUBNORMAL_EN
    logic [EW-1:0]        sh;
`endif

    always_comb begin
        n_m     = acc_q;
        n_e     = exp_q;
        n_st    = 1'b0;
        n_flush = 1'b0;
`ifdef TMUL_SUBNORMAL_EN
        sh      = '0;
`endif
        if (acc_q[PW-1]) begin
            n_m  = acc_q >> 1;
            n_st = acc_q[0];
            n_e  = exp_q + EW'(1);
        end
        if (n_e[EW-1] || n_e == '0) begin
`ifdef TMUL_SUBNORMAL_EN
            // Exponent 1-n_e below the normal range: denormalise, keep the
            // lost bits in sticky. Shifts >= PW clear n_m entirely.
            sh   = EW'(1) - n_e;
            n_st = n_st | (|(n_m & ~({PW{1'b1}} << sh)));
            n_m  = n_m >> sh;
`else
            n_flush = 1'b1;
`endif
            n_e = '0;
        end
    end

    // ---------------- rounding (RND) ----------------
    logic [W-1:0] rnd_word, res_d;

    float_round #(.EXP(EXP), .FRA(FRA)) u_round (
        .sign       (sign_q),
        .biased_exp ($unsigned(exp_q)),
        .sig        (acc_q[2*FRA:FRA]),
        .guard      (acc_q[FRA-1]),
        .round      (acc_q[FRA-2]),
        .sticky     (sticky_q | (|acc_q[FRA-3:0])),
        .word       (rnd_word)
    );

    always_comb begin
        if (nan_q)
            res_d = NAN_W;
        else if (inf_q)
            res_d = {sign_q, EONES, {FRA{1'b0}}};
        else if (zero_q || flush_q)
            res_d = {sign_q, {(W-1){1'b0}}};
        else
            res_d = rnd_word;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (s_axis_a_tvalid && s_axis_b_tvalid) state_d = ST_PRE;
            ST_PRE:  state_d = ST_MUL;
            ST_MUL:  if (cnt_q == LAST_ITER) state_d = ST_NORM;
            ST_NORM: state_d = ST_RND;
            ST_RND:  state_d = ST_OUT;
            ST_OUT:  if (m_axis_tready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            sign_q   <= 1'b0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            flush_q  <= 1'b0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (s_axis_a_tvalid && s_axis_b_tvalid) begin
                        a_q <= s_axis_a_tdata;
                        b_q <= s_axis_b_tdata;
                    end
                end
                ST_PRE: begin
                    sign_q   <= a_q[W-1] ^ b_q[W-1];
                    nan_q    <= pre_nan;
                    inf_q    <= a_inf | b_inf;
                    zero_q   <= a_zero | b_zero;
                    exp_q    <= up_a[EW+SW-1:SW] + up_b[EW+SW-1:SW] - BIAS_E;
                    mcand_q  <= {{SW{1'b0}}, up_a[SW-1:0]};
                    mplier_q <= up_b[SW-1:0];
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end
                ST_MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                end
                ST_NORM: begin
                    acc_q    <= n_m;
                    exp_q    <= n_e;
                    sticky_q <= n_st;
                    flush_q  <= n_flush;
                end
                ST_RND:  res_q <= res_d;
                default: ;
            endcase
        end
    end

    assign s_axis_a_tready = aresetn && (state_q == ST_IDLE);
    assign s_axis_b_tready = aresetn && (state_q == ST_IDLE);
    assign m_axis_tvalid   = (state_q == ST_OUT);
    assign m_axis_tdata    = res_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_tmul.sv
// -----------------------------------------------------------------------------
// tb_tmul
// Directed self-checking bench for tmul at half precision (EXP=5, FRA=10).
// -----------------------------------------------------------------------------
module tb_tmul;
    import float_pkg::*;

    localparam int EXP    = 5;
    localparam int FRA    = 10;
    localparam int W      = EXP + FRA + 1;
    localparam int LAT    = FRA + 5;
    localparam int PERIOD = FRA + 6;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [W-1:0] a_data, b_data;
    logic         a_valid, b_valid;
    logic         s_axis_a_tready, s_axis_b_tready;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_tready;
    state_e       dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    tmul #(.EXP(EXP), .FRA(FRA)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis_a_tdata  (a_data),
        .s_axis_a_tvalid (a_valid),
        .s_axis_a_tready (s_axis_a_tready),
        .s_axis_b_tdata  (b_data),
        .s_axis_b_tvalid (b_valid),
        .s_axis_b_tready (s_axis_b_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_tready),
        .dbg_state       (dbg_state)
    );

    // ---------------- driver ----------------
    // Presents one operand pair, waits for the result. lat counts negedges from
    // the accept cycle (cycle t) to the first cycle with tvalid high; 0 means
    // no result within the budget. Returns after the output handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int lat);
        int n;
        bit got;
        res = '0;
        lat = 0;
        got = 1'b0;
        @(negedge aclk);
        a_data  = a;
        b_data  = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        n = 0;
        while (!(s_axis_a_tready && s_axis_b_tready) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        for (int c = 1; c <= 60; c++) begin
            @(negedge aclk);
            a_valid = 1'b0;
            b_valid = 1'b0;
            if (m_axis_tvalid) begin
                res = m_axis_tdata;
                lat = c;
                got = 1'b1;
                break;
            end
        end
        if (got) @(negedge aclk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn  = 1'b0;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        a_data   = '0;
        b_data   = '0;
        m_tready = 1'b1;
        repeat (3) @(negedge aclk);
        n_vec++;
        if (s_axis_a_tready !== 1'b0 || s_axis_b_tready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tready_low: got a=%b b=%b expected 0 0", s_axis_a_tready, s_axis_b_tready);
        end
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid);
        end
        n_vec++;
        if (m_axis_tdata !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_tdata: got %h expected 0000", m_axis_tdata);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        n_vec++;
        if (s_axis_a_tready !== 1'b1 || s_axis_b_tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tready_high: got a=%b b=%b expected 1 1", s_axis_a_tready, s_axis_b_tready);
        end
        n_vec++;
        if (dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] ta[7], tv[7], te[7];
        logic [W-1:0] res;
        int lat;
        ta[0] = 16'h4000; tv[0] = 16'h4200; te[0] = 16'h4600; // 2*3 = 6
        ta[1] = 16'h3266; tv[1] = 16'h4D00; te[1] = 16'h4400; // RNE tie, carry into exp
        ta[2] = 16'hC000; tv[2] = 16'h4200; te[2] = 16'hC600; // -2*3 = -6
        ta[3] = 16'h7BFF; tv[3] = 16'h4000; te[3] = 16'h7C00; // overflow to +inf
        ta[4] = 16'h3E00; tv[4] = 16'h3E00; te[4] = 16'h4080; // 1.5*1.5, product MSB set
        ta[5] = 16'h3C00; tv[5] = 16'h3C00; te[5] = 16'h3C00; // 1*1
        ta[6] = 16'h4200; tv[6] = 16'hC200; te[6] = 16'hC880; // 3*-3 = -9
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tv[i], res, lat);
            n_vec++;
            if (res !== te[i]) begin
                n_err++;
                $display("FAIL arith_%0d_result: got %h expected %h (%h x %h)", i, res, te[i], ta[i], tv[i]);
            end
            n_vec++;
            if (lat !== LAT) begin
                n_err++;
                $display("FAIL arith_%0d_latency: got %0d expected %0d", i, lat, LAT);
            end
        end
    endtask

    task automatic test_specials();
        logic [W-1:0] ta[4], tv[4], te[4];
        logic [W-1:0] res;
        int lat;
        ta[0] = 16'h7C00; tv[0] = 16'h0000; te[0] = 16'h7E00; // inf * 0 -> NaN
        ta[1] = 16'h7E01; tv[1] = 16'h3C00; te[1] = 16'h7E00; // NaN in -> canonical NaN
        ta[2] = 16'h0000; tv[2] = 16'hC200; te[2] = 16'h8000; // 0 * -3 -> -0
        ta[3] = 16'hFC00; tv[3] = 16'h4200; te[3] = 16'hFC00; // -inf * 3 -> -inf
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tv[i], res, lat);
            n_vec++;
            if (res !== te[i]) begin
                n_err++;
                $display("FAIL special_%0d_result: got %h expected %h (%h x %h)", i, res, te[i], ta[i], tv[i]);
            end
            n_vec++;
            if (lat !== LAT) begin
                n_err++;
                $display("FAIL special_%0d_latency: got %0d expected %0d", i, lat, LAT);
            end
        end
    endtask

    task automatic test_subnormal();
        logic [W-1:0] res, want;
        int lat;
`ifdef TMUL_SUBNORMAL_EN
        want = 16'h0002;
`else
        want = 16'h0000;
`endif
        do_op(16'h0001, 16'h4000, res, lat);
        n_vec++;
        if (res !== want) begin
            n_err++;
            $display("FAIL subnormal_result: got %h expected %h", res, want);
        end
        n_vec++;
        if (lat !== LAT) begin
            n_err++;
            $display("FAIL subnormal_latency: got %0d expected %0d", lat, LAT);
        end
    endtask

    task automatic test_one_valid();
        logic [W-1:0] res;
        int lat;
        @(negedge aclk);
        a_data  = 16'h4000;
        b_data  = 16'h4000;
        a_valid = 1'b1;
        b_valid = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            n_vec++;
            if (s_axis_a_tready !== 1'b1 || s_axis_b_tready !== 1'b1 ||
                dbg_state !== ST_IDLE || m_axis_tvalid !== 1'b0) begin
                n_err++;
                $display("FAIL one_valid_idle: got rdy=%b%b state=%0d tvalid=%b expected rdy=11 state=0 tvalid=0",
                         s_axis_a_tready, s_axis_b_tready, dbg_state, m_axis_tvalid);
            end
        end
        a_valid = 1'b0;
        do_op(16'h4000, 16'h4000, res, lat);
        n_vec++;
        if (res !== 16'h4400) begin
            n_err++;
            $display("FAIL one_valid_followup: got %h expected 4400", res);
        end
    endtask

    task automatic test_backpressure();
        int n;
        m_tready = 1'b0;
        @(negedge aclk);
        a_data  = 16'h4200;
        b_data  = 16'h4200;
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge aclk);
        a_data = 16'h4000;  // next operands wait while the FSM is busy
        b_data = 16'h4000;
        n = 0;
        while (m_axis_tvalid !== 1'b1 && n < 60) begin
            @(negedge aclk);
            n++;
        end
        n_vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h4880) begin
            n_err++;
            $display("FAIL bp_first_result: got tvalid=%b data=%h expected 1 4880", m_axis_tvalid, m_axis_tdata);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            n_vec++;
            if (m_axis_tdata !== 16'h4880 || m_axis_tvalid !== 1'b1 ||
                s_axis_a_tready !== 1'b0 || s_axis_b_tready !== 1'b0 || dbg_state !== ST_OUT) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got data=%h tvalid=%b rdy=%b%b state=%0d expected 4880 1 00 %0d",
                         i, m_axis_tdata, m_axis_tvalid, s_axis_a_tready, s_axis_b_tready, dbg_state, ST_OUT);
            end
        end
        m_tready = 1'b1;
        @(negedge aclk);   // output handshake done, IDLE now, pending pair accepted next edge
        @(negedge aclk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        n = 0;
        while (m_axis_tvalid !== 1'b1 && n < 60) begin
            @(negedge aclk);
            n++;
        end
        n_vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h4400) begin
            n_err++;
            $display("FAIL bp_next_result: got tvalid=%b data=%h expected 1 4400", m_axis_tvalid, m_axis_tdata);
        end
        @(negedge aclk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge aclk);
        a_data  = 16'h4000;
        b_data  = 16'h4200;
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge aclk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (3) @(negedge aclk);
        n_vec++;
        if (dbg_state !== ST_MUL) begin
            n_err++;
            $display("FAIL mid_reset_in_mul: got %0d expected %0d", dbg_state, ST_MUL);
        end
        aresetn = 1'b0;
        #1;
        n_vec++;
        if (s_axis_a_tready !== 1'b0 || s_axis_b_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got rdy=%b%b tvalid=%b expected 00 0",
                     s_axis_a_tready, s_axis_b_tready, m_axis_tvalid);
        end
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL mid_reset_no_output: got tvalid seen=1 expected 0");
        end
        n_vec++;
        if (dbg_state !== ST_IDLE || m_axis_tdata !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset_idle: got state=%0d data=%h expected 0 0000", dbg_state, m_axis_tdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va[4], vb[4], ve[4];
        logic [W-1:0] e;
        int idx, out_cnt, last_acc;
        va[0] = 16'h4000; vb[0] = 16'h4200; ve[0] = 16'h4600;
        va[1] = 16'hC000; vb[1] = 16'h4200; ve[1] = 16'hC600;
        va[2] = 16'h3E00; vb[2] = 16'h3E00; ve[2] = 16'h4080;
        va[3] = 16'h3C00; vb[3] = 16'h3C00; ve[3] = 16'h3C00;
        exp_q.delete();
        idx      = 0;
        out_cnt  = 0;
        last_acc = -1;
        m_tready = 1'b1;
        @(negedge aclk);
        a_data  = va[0];
        b_data  = vb[0];
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int c = 0; c < 200 && out_cnt < 4; c++) begin
            if (m_axis_tvalid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_unexpected: got %h expected no output", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e) begin
                        n_err++;
                        $display("FAIL b2b_result_%0d: got %h expected %h", out_cnt, m_axis_tdata, e);
                    end
                end
                out_cnt++;
            end
            if (a_valid && s_axis_a_tready && s_axis_b_tready) begin
                exp_q.push_back(ve[idx]);
                if (last_acc >= 0) begin
                    n_vec++;
                    if (cyc - last_acc !== PERIOD) begin
                        n_err++;
                        $display("FAIL b2b_interval_%0d: got %0d expected %0d", idx, cyc - last_acc, PERIOD);
                    end
                end
                last_acc = cyc;
                idx++;
                @(negedge aclk);
                if (idx < 4) begin
                    a_data = va[idx];
                    b_data = vb[idx];
                end else begin
                    a_valid = 1'b0;
                    b_valid = 1'b0;
                end
            end else begin
                @(negedge aclk);
            end
        end
        n_vec++;
        if (out_cnt !== 4 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d outputs (%0d pending) expected 4 (0 pending)", out_cnt, exp_q.size());
        end
        @(negedge aclk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_arith();
        test_specials();
        test_subnormal();
        test_one_valid();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
